// File: rtl/nark_pipeline_controller.sv
// Control unit for the 4-stage NARK datapath: decodes, evaluates conditions against NZCV,
// stages controls down D->E->M->W and squashes the shadow of taken branches.
module nark_pipeline_controller #(
    parameter int BITS   = 24,
    parameter int SHADOW = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [BITS-1:0] Instr,
    input  logic [3:0]      ALUFlags,
    output logic            ImmSrc,
    output logic            ALUSrc,
    output logic [1:0]      ALUControl,
    output logic            MemWrite,
    output logic            MentoReg,
    output logic            RegWrite,
    output logic            PCSrc,
    output logic [3:0]      Flags,
    output logic            Squashing
);
    localparam int CW = (SHADOW < 2) ? 1 : $clog2(SHADOW + 1);

    typedef struct packed {
        logic       alusrc;
        logic [1:0] alucontrol;
        logic       regwrite;
        logic       memwrite;
        logic       mentoreg;
        logic       flagwrite;
        logic       branch;
        logic [3:0] cond;
    } e_ctrl_t;

    typedef struct packed {
        logic memwrite;
        logic regwrite;
        logic mentoreg;
        logic pcsrc;
    } m_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic mentoreg;
        logic pcsrc;
    } w_ctrl_t;

    e_ctrl_t       dec;
    e_ctrl_t       e_d, e_q;
    m_ctrl_t       m_d, m_q;
    w_ctrl_t       w_d, w_q;
    logic [3:0]    flags_d, flags_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic          cond_ex;
    logic          taken;
    logic          flag_n, flag_z, flag_c, flag_v;
    logic          unused_instr;

    assign unused_instr = ^Instr;

    always_comb begin
        dec      = '0;
        dec.cond = Instr[23:20];
        case (Instr[19:18])
            2'b00: begin
                dec.alusrc     = Instr[17];
                dec.alucontrol = Instr[16:15];
                dec.regwrite   = 1'b1;
                dec.flagwrite  = Instr[14];
            end
            2'b01: begin
                dec.alusrc = 1'b1;
                if (Instr[14]) begin
                    dec.regwrite = 1'b1;
                    dec.mentoreg = 1'b1;
                end else begin
                    dec.memwrite = 1'b1;
                end
            end
            2'b10: begin
                dec.alusrc = 1'b1;
                dec.branch = 1'b1;
            end
            default: dec = '0;
        endcase
    end

    assign ImmSrc = (Instr[19:18] == 2'b10) && !RST;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (e_q.cond)
            4'h0: cond_ex = flag_z;
            4'h1: cond_ex = !flag_z;
            4'h2: cond_ex = flag_c;
            4'h3: cond_ex = !flag_c;
            4'h4: cond_ex = flag_n;
            4'h5: cond_ex = !flag_n;
            4'h6: cond_ex = flag_v;
            4'h7: cond_ex = !flag_v;
            4'h8: cond_ex = flag_c && !flag_z;
            4'h9: cond_ex = !flag_c || flag_z;
            4'hA: cond_ex = (flag_n == flag_v);
            4'hB: cond_ex = (flag_n != flag_v);
            4'hC: cond_ex = !flag_z && (flag_n == flag_v);
            4'hD: cond_ex = flag_z || (flag_n != flag_v);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign taken = e_q.branch && cond_ex;

    // The counter's next value decides whether the instruction now entering E is a
    // shadow victim, so the youngest instruction is already killed on the resolving edge.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else if (taken) begin
            cnt_d = CW'(SHADOW);
        end
        e_d = (cnt_d != '0) ? '0 : dec;
    end

    always_comb begin
        m_d.memwrite = e_q.memwrite && cond_ex;
        m_d.regwrite = e_q.regwrite && cond_ex;
        m_d.mentoreg = e_q.mentoreg;
        m_d.pcsrc    = taken;
        w_d.regwrite = m_q.regwrite;
        w_d.mentoreg = m_q.mentoreg;
        w_d.pcsrc    = m_q.pcsrc;
        flags_d      = (e_q.flagwrite && cond_ex) ? ALUFlags : flags_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ALUSrc     = e_q.alusrc;
    assign ALUControl = e_q.alucontrol;
    assign MemWrite   = m_q.memwrite;
    assign RegWrite   = w_q.regwrite;
    assign MentoReg   = w_q.mentoreg;
    assign PCSrc      = w_q.pcsrc;
    assign Flags      = flags_q;
    assign Squashing  = (cnt_q != '0);

endmodule

// File: tb/tb_nark_pipeline_controller.sv
// Randomized bench for nark_pipeline_controller against an instruction-level model that
// tracks flags, the kill count behind taken branches, and when each effect becomes visible.
module tb_nark_pipeline_controller;
    localparam int BITS   = 24;
    localparam int SHADOW = 3;
    localparam int N      = 2048;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic [BITS-1:0] Instr = '0;
    logic [3:0]      ALUFlags = '0;
    logic            ImmSrc, ALUSrc, MemWrite, MentoReg, RegWrite, PCSrc, Squashing;
    logic [1:0]      ALUControl;
    logic [3:0]      Flags;

    nark_pipeline_controller #(.BITS(BITS), .SHADOW(SHADOW)) dut (
        .CLK(CLK), .RST(RST), .Instr(Instr), .ALUFlags(ALUFlags),
        .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .MemWrite(MemWrite), .MentoReg(MentoReg), .RegWrite(RegWrite),
        .PCSrc(PCSrc), .Flags(Flags), .Squashing(Squashing)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int valid_from = 1;
    int shadow_left = 0;
    logic [3:0]      m_flags = '0;
    logic [BITS-1:0] instr_h [N];
    logic            exp_mw [N];
    logic            exp_rw [N];
    logic            exp_mtr[N];
    logic            exp_pcs[N];

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BITS-1:0] mk(input logic [3:0] c, input logic [1:0] op,
                                           input logic i, input logic [1:0] cmd, input logic s);
        return {c, op, i, cmd, s, 14'h0};
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            exp_mw[k] = 1'b0; exp_rw[k] = 1'b0; exp_mtr[k] = 1'b0; exp_pcs[k] = 1'b0;
        end
        m_flags = '0;
        shadow_left = 0;
    endtask

    // Called at the falling edge of cycle cyc: judge the instruction sitting in execute.
    task automatic model_cycle();
        logic [BITS-1:0] e;
        logic bub, sq, pass, fw, taken, e_as;
        logic [1:0] e_ac;
        e_as = 1'b0; e_ac = 2'b00; fw = 1'b0; taken = 1'b0; pass = 1'b0;
        bub = (cyc - 1 < valid_from);
        e = bub ? '0 : instr_h[cyc - 1];
        sq = (shadow_left > 0);
        if (sq) begin
            shadow_left--;
        end else if (!bub) begin
            pass = cond_ok(e[23:20], m_flags);
            case (e[19:18])
                2'b00: begin
                    e_as = e[17]; e_ac = e[16:15]; fw = e[14];
                    exp_rw[cyc + 2] = pass;
                end
                2'b01: begin
                    e_as = 1'b1;
                    if (e[14]) begin
                        exp_rw[cyc + 2] = pass;
                        exp_mtr[cyc + 2] = 1'b1;
                    end else begin
                        exp_mw[cyc + 1] = pass;
                    end
                end
                2'b10: begin
                    e_as = 1'b1; taken = pass;
                    exp_pcs[cyc + 2] = pass;
                end
                default: ;
            endcase
        end
        check_val("ImmSrc",     8'(ImmSrc),     8'(instr_h[cyc][19:18] == 2'b10));
        check_val("ALUSrc",     8'(ALUSrc),     8'(e_as));
        check_val("ALUControl", 8'(ALUControl), 8'(e_ac));
        check_val("MemWrite",   8'(MemWrite),   8'(exp_mw[cyc]));
        check_val("RegWrite",   8'(RegWrite),   8'(exp_rw[cyc]));
        check_val("MentoReg",   8'(MentoReg),   8'(exp_mtr[cyc]));
        check_val("PCSrc",      8'(PCSrc),      8'(exp_pcs[cyc]));
        check_val("Flags",      8'(Flags),      8'(m_flags));
        check_val("Squashing",  8'(Squashing),  8'(sq));
        $display("cyc=%0d D=%h E=%h sq=%b AS=%b AC=%b MW=%b RW=%b MR=%b PC=%b NZCV=%b",
                 cyc, instr_h[cyc], e, Squashing, ALUSrc, ALUControl, MemWrite,
                 RegWrite, MentoReg, PCSrc, Flags);
        if (fw && pass) m_flags = ALUFlags;
        if (taken) shadow_left = SHADOW;
    endtask

    task automatic run_cycle(input logic [BITS-1:0] ins, input logic [3:0] af);
        @(posedge CLK);
        #1;
        Instr = ins;
        ALUFlags = af;
        cyc++;
        instr_h[cyc] = ins;
        @(negedge CLK);
        model_cycle();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_ImmSrc"},  8'(ImmSrc),     8'h0);
        check_val({tag, "_ALU"},     {5'(0), ALUSrc, ALUControl}, 8'h0);
        check_val({tag, "_Wb"},      {4'(0), MemWrite, RegWrite, MentoReg, PCSrc}, 8'h0);
        check_val({tag, "_Flags"},   8'(Flags),     8'h0);
        check_val({tag, "_Squash"},  8'(Squashing), 8'h0);
    endtask

    // Raise RST asynchronously mid-cycle with a branch in decode, hold across an edge,
    // then release with a never-executing instruction on the bus.
    task automatic do_reset();
        @(posedge CLK);
        #1 Instr = mk(4'hE, 2'b10, 1'b0, 2'b00, 1'b0);
        #1 RST = 1'b1;
        #1 check_zero("rst_async");
        @(posedge CLK);
        @(negedge CLK);
        check_zero("rst_held");
        Instr = mk(4'hF, 2'b00, 1'b0, 2'b00, 1'b0);
        RST = 1'b0;
        clear_model();
        valid_from = cyc + 1;
    endtask

    logic [BITS-1:0] r_ins;
    localparam logic [3:0] AL = 4'hE;

    initial begin
        for (int k = 0; k < N; k++) instr_h[k] = '0;
        clear_model();
        do_reset();

        run_cycle(mk(AL, 2'b00, 1'b1, 2'b00, 1'b0), 4'h0);    // ADD imm
        run_cycle(mk(AL, 2'b00, 1'b0, 2'b01, 1'b1), 4'h0);    // SUBS
        run_cycle(mk(4'h0, 2'b00, 1'b1, 2'b00, 1'b0), 4'b0100); // ADDEQ (SUBS in E)
        run_cycle(mk(4'h1, 2'b00, 1'b1, 2'b00, 1'b0), 4'h0);  // ADDNE
        run_cycle(mk(AL, 2'b01, 1'b0, 2'b00, 1'b0), 4'h0);    // store
        run_cycle(mk(AL, 2'b01, 1'b0, 2'b00, 1'b1), 4'h0);    // load
        run_cycle(mk(AL, 2'b10, 1'b0, 2'b00, 1'b0), 4'h0);    // B
        for (int k = 0; k < 4; k++) run_cycle(mk(AL, 2'b00, 1'b1, 2'b10, 1'b0), 4'h0);
        run_cycle(mk(AL, 2'b00, 1'b0, 2'b01, 1'b1), 4'h0);    // SUBS
        run_cycle(mk(4'h0, 2'b10, 1'b0, 2'b00, 1'b0), 4'b0000); // BEQ with Z=0
        run_cycle(mk(4'hF, 2'b00, 1'b1, 2'b11, 1'b1), 4'b1111); // never
        run_cycle(mk(AL, 2'b00, 1'b1, 2'b11, 1'b0), 4'h0);
        for (int k = 0; k < 3; k++) run_cycle(mk(AL, 2'b00, 1'b0, 2'b00, 1'b0), 4'h0);
        run_cycle(mk(AL, 2'b10, 1'b0, 2'b00, 1'b0), 4'h0);    // B, then reset at count 2
        run_cycle(mk(AL, 2'b00, 1'b1, 2'b00, 1'b0), 4'h0);
        run_cycle(mk(AL, 2'b00, 1'b1, 2'b00, 1'b0), 4'h0);
        do_reset();
        for (int k = 0; k < 5; k++) run_cycle(mk(AL, 2'b00, 1'b1, 2'b00, 1'b0), 4'h0);

        for (int k = 0; k < 600; k++) begin
            r_ins = BITS'($urandom);
            if ($urandom_range(1, 0) == 1) r_ins[23:20] = AL;
            if ($urandom_range(150, 0) == 0) do_reset();
            run_cycle(r_ins, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
